// File: rtl/divider_arbiter_if.sv
// divider_arbiter_if: client request/result signals for channels 1 and 2 plus the shared divider port
//    r1_*/r2_* : per-channel operands, start pulse, held quotient, rdy level, abort flag
//    d_*       : divider operands, start pulse, quotient and completion pulse
//    slave     : arbiter view
//    master    : environment view (clients and divider)
interface divider_arbiter_if;
   logic [31:0] r1_in1, r1_in2, r1_out, r2_in1, r2_in2, r2_out;
   logic        r1_start, r1_rdy, r1_err, r2_start, r2_rdy, r2_err;
   logic [31:0] d_in1, d_in2, d_out;
   logic        d_start, d_rdy;
   modport slave (
      input  r1_in1, r1_in2, r1_start, r2_in1, r2_in2, r2_start, d_out, d_rdy,
      output r1_out, r1_rdy, r1_err, r2_out, r2_rdy, r2_err, d_in1, d_in2, d_start
   );
   modport master (
      output r1_in1, r1_in2, r1_start, r2_in1, r2_in2, r2_start, d_out, d_rdy,
      input  r1_out, r1_rdy, r1_err, r2_out, r2_rdy, r2_err, d_in1, d_in2, d_start
   );
endinterface

// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one sequential divider between two start/rdy clients
//    clk    : clock, all logic on posedge
//    rst    : synchronous active-low reset
//    io_bus : channel 1/2 request ports (rN_*) and divider port (d_*)
//    PAIRED : 1 = both rdy lines assert only when both channels hold a result
//    TIMEOUT: WAIT cycles allowed before an operation is aborted
module divider_arbiter #(
   parameter bit PAIRED  = 1'b1,
   parameter int TIMEOUT = 1023
) (
   input logic              clk,
   input logic              rst,
   divider_arbiter_if.slave io_bus
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_op1 [2];
   logic [31:0] r_op2 [2];
   logic [31:0] r_res [2];
   logic [1:0]  r_pend, r_busy, r_stale, r_done, r_err;
   logic        r_last, r_g;
   logic [9:0]  r_wd;
   logic [1:0]  w_start;
   logic        w_grant, w_g, w_to, w_fin, w_drop;
   // index 0 is channel 1, index 1 is channel 2; a tie goes to the channel not served last
   assign w_start = {io_bus.r2_start, io_bus.r1_start};
   assign w_grant = (r_state == IDLE) && (r_pend != 2'b00);
   assign w_g     = (r_pend == 2'b11) ? ~r_last : r_pend[1];
   assign w_to    = (r_state == WAIT) && !io_bus.d_rdy && (r_wd == 10'(TIMEOUT - 1));
   assign w_fin   = (r_state == WAIT) && (io_bus.d_rdy || w_to);
   // a restart landing on the completion cycle also orphans the result
   assign w_drop  = r_stale[r_g] | w_start[r_g];
   always_ff @(posedge clk) r_state <= !rst ? IDLE : w_next;
   always_comb w_next = (r_state == IDLE) ? (w_grant ? WAIT : IDLE) : (w_fin ? IDLE : WAIT);
   always_comb begin
      io_bus.d_start = w_grant;
      io_bus.d_in1   = w_grant ? r_op1[w_g] : '0;
      io_bus.d_in2   = w_grant ? r_op2[w_g] : '0;
      io_bus.r1_out  = r_res[0];
      io_bus.r2_out  = r_res[1];
      io_bus.r1_err  = r_err[0];
      io_bus.r2_err  = r_err[1];
      io_bus.r1_rdy  = PAIRED ? &r_done : r_done[0];
      io_bus.r2_rdy  = PAIRED ? &r_done : r_done[1];
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_last  <= 1'b1;
         r_g     <= 1'b0;
         r_wd    <= '0;
         r_pend  <= '0;
         r_busy  <= '0;
         r_stale <= '0;
         r_done  <= '0;
         r_err   <= '0;
         r_op1   <= '{default: '0};
         r_op2   <= '{default: '0};
         r_res   <= '{default: '0};
      end else begin
         r_wd <= w_grant ? '0 : r_wd + 10'd1;
         if (w_grant) begin
            r_g    <= w_g;
            r_last <= w_g;
         end
         for (int c = 0; c < 2; c++) begin
            if (w_fin && r_g == 1'(c)) begin
               r_busy[c]  <= 1'b0;
               r_stale[c] <= 1'b0;
               if (!w_drop) begin
                  r_res[c]  <= w_to ? '1 : io_bus.d_out;
                  r_done[c] <= 1'b1;
                  r_err[c]  <= w_to;
               end
            end
            if (w_grant && w_g == 1'(c)) begin
               r_pend[c] <= 1'b0;
               r_busy[c] <= 1'b1;
            end
            if (w_start[c]) begin
               r_op1[c]  <= (c == 0) ? io_bus.r1_in1 : io_bus.r2_in1;
               r_op2[c]  <= (c == 0) ? io_bus.r1_in2 : io_bus.r2_in2;
               r_pend[c] <= 1'b1;
               r_done[c] <= 1'b0;
               r_err[c]  <= 1'b0;
               // the issued operand set (still in flight or issued this very cycle) is superseded
               if ((r_busy[c] && !(w_fin && r_g == 1'(c))) || (w_grant && w_g == 1'(c)))
                  r_stale[c] <= 1'b1;
            end
         end
      end
   end
endmodule
